seg7_count_sequencer: RTL
=========================

# seg7_count_sequencer

Run/stop controller and display scheduler for the 8-bit display counter. It debounces the run and clear pushbuttons, tracks run state in a small FSM, and paces the counter with one-cycle `count_en` ticks from a prescaler. It also time-multiplexes the counter value onto the shared `seg7` decoder as two hex digits. The counter register and the `seg7` decoder stay external: this block only sequences them.

## Interface
- `PRESCALE`, default 1000: clk cycles per count tick; minimum 2.
- `DEBOUNCE`, default 16: consecutive stable synchronized samples required to accept a button level change; minimum 2.
- `MUX_PERIOD`, default 64: clk cycles each digit is displayed; minimum 1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `btn_run` in 1: raw asynchronous run/stop pushbutton, active high.
- `btn_clr` in 1: raw asynchronous clear pushbutton, active high.
- `count` in 8: current external counter value.
- `count_en` out 1: one-cycle pulse; the counter increments by 1 (mod 256).
- `count_clr` out 1: one-cycle pulse; the counter loads 8'h00.
- `running` out 1: high while the FSM is in RUN.
- `digit_sel` out 2: one-hot digit enable, active high; 2'b01 selects the low nibble, 2'b10 selects the high nibble.
- `digit_val` out 4: nibble to the `seg7` decoder input.

## Operation
- **Input conditioning:**
  - Each button passes through a 2-FF synchronizer, then a per-button debounce counter.
  - The debounced level changes only after `DEBOUNCE` consecutive synchronized samples differ from it.
  - A "press" is a single-cycle pulse on each debounced 0→1 edge. Releases generate nothing.
- **FSM states:** IDLE, RUN, PAUSE.
  - IDLE + run press → RUN.
  - RUN + run press → PAUSE.
  - PAUSE + run press → RUN.
  - Clear press from any state → IDLE, with one `count_clr` pulse.
  - Run press and clear press in the same cycle: clear wins; the state goes to IDLE.
- **Prescaler:** `p`, width ceil(log2(`PRESCALE`)).
  - Increments only in RUN. At `p`==`PRESCALE`-1 it wraps to 0 and asserts `count_en` for that cycle.
  - In PAUSE, `p` holds its value, so resuming completes the partial period.
  - In IDLE or on a clear press, `p` goes to 0.
  - `count_en` and `count_clr` are never high in the same cycle; clear suppresses any tick due that cycle.
- **Display mux:**
  - A free-running counter (0..`MUX_PERIOD`-1) toggles `digit_sel` on wrap, independent of FSM state.
  - `digit_val` = `count[3:0]` when `digit_sel`==2'b01, and `count[7:4]` when 2'b10.
  - `digit_val` is combinational from `count` and the registered `digit_sel`.
- **Reset values while `rst_n`=0 at a clk edge:**
  - state IDLE, `running`=0, `count_en`=0, `count_clr`=0.
  - `digit_sel`=2'b01; prescaler, mux counter, synchronizers and debounce levels all 0.
- **Reset mid-operation:** all state is discarded. A button held through reset is seen as a new press once `DEBOUNCE` samples after release of reset accept it.

## Timing
- `count_en`, `count_clr`, `running` and `digit_sel` are registered outputs.
- **Press latency:** the raw button rises before edge 0. The synchronized level is valid after edge 2. The debounced level rises at edge 2+`DEBOUNCE`. The state and `running` update, and `count_clr` pulses, at edge 3+`DEBOUNCE`.
- **Tick timing:** the first `count_en` pulse comes `PRESCALE` cycles after `running` rises from IDLE. After that, `count_en` pulses exactly once every `PRESCALE` cycles while in RUN.
- **Digit dwell:** `digit_sel` holds each value for exactly `MUX_PERIOD` cycles. The first toggle after reset is at edge `MUX_PERIOD`.
- A button glitch shorter than `DEBOUNCE` synchronized cycles produces no press.

## Configuration
- Macro: `SEQ_AUTOSTOP_EN`.
- **Defined:** in RUN, when a tick is due and `count`==8'hFF, no `count_en` is issued. The FSM moves to PAUSE and `p` goes to 0. The counter therefore stops at 8'hFF.
- **Undefined:** the tick is issued normally and the counter wraps 8'hFF→8'h00. The FSM stays in RUN.

## Test plan
All scenarios use `PRESCALE`=4, `DEBOUNCE`=3 and `MUX_PERIOD`=2.
- **Reset:** hold `rst_n`=0 for 2 cycles, then release → `running`=0, `count_en`=0, `count_clr`=0, `digit_sel`=01; `digit_sel` toggles to 10 at the second edge after release.
- **Glitch rejection:** `btn_run` high for 2 cycles, then low → `running` stays 0.
- **Run/pause/resume:** `btn_run` high for 6 cycles → `running`=1 at edge 6 after the rise and the first `count_en` 4 cycles later. Press again mid-period at `p`=2 → PAUSE, no pulses. Press again → the next `count_en` comes 2 cycles after `running` rises.
- **Clear priority:** raw rises of `btn_run` and `btn_clr` on the same edge while in RUN → a single `count_clr` pulse, state IDLE, no `count_en` afterwards.
- **Mux:** `count`=8'hA5 → `digit_val` alternates 4'h5 and 4'hA every 2 cycles, following `digit_sel` 01/10.
- **Wrap vs. autostop:** with `count`=8'hFF in RUN at the tick → a `count_en` pulse and RUN retained when `SEQ_AUTOSTOP_EN` is undefined; no pulse, `running`=0 and PAUSE when it is defined.

Source files
------------

// File: rtl/seg7_count_sequencer_if.sv
// Bundle between the run/stop sequencer and the board-level controls,
// the external 8-bit counter and the shared seg7 decoder.
interface seg7_count_sequencer_if;
    logic       btn_run;
    logic       btn_clr;
    logic [7:0] count;
    logic       count_en;
    logic       count_clr;
    logic       running;
    logic [1:0] digit_sel;
    logic [3:0] digit_val;

    modport master (
        output btn_run, btn_clr, count,
        input  count_en, count_clr, running, digit_sel, digit_val
    );

    modport slave (
        input  btn_run, btn_clr, count,
        output count_en, count_clr, running, digit_sel, digit_val
    );
endinterface

// File: rtl/seg7_count_sequencer.sv
// Run/stop FSM, tick prescaler and two-digit display mux for the counter.
// Optional SEQ_AUTOSTOP_EN: pause at 8'hFF instead of wrapping.
module seg7_count_sequencer #(
    parameter int PRESCALE   = 1000,
    parameter int DEBOUNCE   = 16,
    parameter int MUX_PERIOD = 64
) (
    input logic                   clk,
    input logic                   rst_n,
    seg7_count_sequencer_if.slave bus
);
    localparam int PW = $clog2(PRESCALE);
    localparam int DW = $clog2(DEBOUNCE);
    localparam int MW = (MUX_PERIOD > 1) ? $clog2(MUX_PERIOD) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [MW-1:0] M_LAST  = MW'(MUX_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // bit 0 = run button, bit 1 = clear button
    logic [1:0]         s1_q, s2_q;
    logic [1:0]         lvl_q, lvl_d;
    logic [1:0]         prev_q;
    logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]         press;
    logic               run_press, clr_press;

    state_t             state_q, state_d;
    logic [PW-1:0]      p_q, p_d;
    logic               count_en_q, count_en_d;
    logic               count_clr_q, count_clr_d;
    logic               running_q, running_d;

    logic [MW-1:0]      mux_q, mux_d;
    logic [1:0]         digit_sel_q, digit_sel_d;

    // Debounce: accept a new level after DEBOUNCE differing samples
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lvl_d[i]    = lvl_q[i];
            db_cnt_d[i] = '0;
            if (s2_q[i] != lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    lvl_d[i] = s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press     = lvl_q & ~prev_q;
    assign run_press = press[0];
    assign clr_press = press[1];

    // Next state, prescaler and output pulses; clear always wins
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        count_en_d  = 1'b0;
        count_clr_d = 1'b0;
        if (clr_press) begin
            state_d     = IDLE;
            p_d         = '0;
            count_clr_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    p_d = '0;
                    if (run_press) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (run_press) begin
                        state_d = PAUSE;
                    end else if (p_q == P_LAST) begin
                        p_d = '0;
`ifdef SEQ_AUTOSTOP_EN
                        if (bus.count == 8'hFF) begin
                            state_d = PAUSE;
                        end else begin
                            count_en_d = 1'b1;
                        end
`else
                        count_en_d = 1'b1;
`endif
                    end else begin
                        p_d = p_q + 1'b1;
                    end
                end
                PAUSE: begin
                    if (run_press) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    p_d     = '0;
                end
            endcase
        end
        running_d = (state_d == RUN);
    end

    // Free-running digit scan, independent of run state
    always_comb begin
        mux_d       = mux_q + 1'b1;
        digit_sel_d = digit_sel_q;
        if (mux_q == M_LAST) begin
            mux_d       = '0;
            digit_sel_d = {digit_sel_q[0], digit_sel_q[1]};
        end
    end

    // Input synchronizers and debounce state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            lvl_q    <= '0;
            prev_q   <= '0;
            db_cnt_q <= '0;
        end else begin
            s1_q     <= {bus.btn_clr, bus.btn_run};
            s2_q     <= s1_q;
            lvl_q    <= lvl_d;
            prev_q   <= lvl_q;
            db_cnt_q <= db_cnt_d;
        end
    end

    // FSM, prescaler and registered control outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            p_q         <= '0;
            count_en_q  <= 1'b0;
            count_clr_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            count_en_q  <= count_en_d;
            count_clr_q <= count_clr_d;
            running_q   <= running_d;
        end
    end

    // Display mux counter and digit select
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mux_q       <= '0;
            digit_sel_q <= 2'b01;
        end else begin
            mux_q       <= mux_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    assign bus.count_en  = count_en_q;
    assign bus.count_clr = count_clr_q;
    assign bus.running   = running_q;
    assign bus.digit_sel = digit_sel_q;
    assign bus.digit_val = digit_sel_q[1] ? bus.count[7:4] : bus.count[3:0];

endmodule
